// File: rtl/fetch_if.sv
// fetch_if: run-control, instruction-ROM and decode-side signals of the fetch stage
interface fetch_if #(
  parameter int D  = 12,
  parameter int W  = 9,
  parameter int CW = 16
);
  logic          start, stall, flush, pc_en, instr_valid, done;
  logic [D-1:0]  pc_in, imem_addr, instr_pc;
  logic [W-1:0]  imem_data, instr_out;
  logic [CW-1:0] fetch_count;
  modport master (
    output start, pc_in, stall, flush, imem_data,
    input  pc_en, imem_addr, instr_out, instr_pc, instr_valid, done, fetch_count
  );
  modport slave (
    input  start, pc_in, stall, flush, imem_data,
    output pc_en, imem_addr, instr_out, instr_pc, instr_valid, done, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC-driven ROM fetch absorbing 1-cycle ROM latency, with run control and delivered count
module fetch_stage #(
  parameter int           D       = 12,
  parameter int           W       = 9,
  parameter logic [W-1:0] HALT_OP = 9'h1FF,
  parameter int           CW      = 16
) (
  input logic    clk,
  input logic    rst_n,
  fetch_if.slave f
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t       state, state_nx;
  logic [D-1:0] req_pc_q;
  logic         req_valid_q, run, fl, halt_hit, kill;
  assign run      = state == RUN;
  // a start while running is a restart and behaves like a flush
  assign fl       = f.flush | (f.start & run);
  assign halt_hit = f.instr_valid & (f.instr_out == HALT_OP) & ~fl;
  assign kill     = fl | halt_hit;
  assign f.pc_en     = run & ~f.stall & ~halt_hit;
  assign f.imem_addr = f.stall ? req_pc_q : f.pc_in;
  always_comb begin
    state_nx = state;
    state_nx = halt_hit ? HALT : f.start ? RUN : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state         <= IDLE;
      req_pc_q      <= '0;
      req_valid_q   <= 1'b0;
      f.instr_out   <= '0;
      f.instr_pc    <= '0;
      f.instr_valid <= 1'b0;
      f.done        <= 1'b0;
      f.fetch_count <= '0;
    end else begin
      state <= state_nx;
      if (!f.stall) begin
        req_pc_q    <= f.pc_in;
        f.instr_out <= f.imem_data;
        f.instr_pc  <= req_pc_q;
      end
      req_valid_q   <= kill ? 1'b0 : f.stall ? req_valid_q : run;
      f.instr_valid <= kill ? 1'b0 : f.stall ? f.instr_valid : req_valid_q;
      f.done        <= halt_hit | (f.done & ~f.start);
      f.fetch_count <= f.start ? '0 :
                       (f.instr_valid & ~f.stall & ~f.flush & ~&f.fetch_count) ? f.fetch_count + 1'b1 :
                       f.fetch_count;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized run checked against a slot-queue reference model
module tb_fetch_stage;
  localparam int D = 12, W = 9, CW = 16;
  localparam logic [W-1:0] HALT = 9'h1FF;
  logic clk = 0, rst_n = 0, start = 0, stall = 0, flush = 0, jump = 0;
  logic [D-1:0] pc = '0, jump_pc = '0;
  logic [W-1:0] rom [2**D];
  logic [W-1:0] rom_q;
  int pass_cnt = 0, total_cnt = 0;
  fetch_if #(.D(D), .W(W), .CW(CW)) f();
  fetch_if #(.D(D), .W(W), .CW(4))  f4();
  fetch_stage #(.D(D), .W(W), .HALT_OP(HALT), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .f(f));
  fetch_stage #(.D(D), .W(W), .HALT_OP(HALT), .CW(4))  dut4 (.clk(clk), .rst_n(rst_n), .f(f4));
  assign f.start = start;  assign f.stall = stall;  assign f.flush = flush;
  assign f.pc_in = pc;     assign f.imem_data = rom_q;
  assign f4.start = start; assign f4.stall = stall; assign f4.flush = flush;
  assign f4.pc_in = pc;    assign f4.imem_data = rom_q;
  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[f.imem_addr];
  always @(posedge clk)
    if (!rst_n) pc <= '0;
    else if (jump) pc <= jump_pc;
    else if (f.pc_en) pc <= pc + 1'b1;
  // reference: two in-flight slots (oldest = what decode sees), instruction taken straight from ROM by PC
  typedef struct packed {logic v; logic [D-1:0] pc; logic [W-1:0] ins;} slot_t;
  typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
  mstate_t m_state = M_IDLE;
  slot_t   pipe[$];
  logic    m_done = 0;
  int      m_cnt = 0, m_cnt4 = 0;
  function automatic logic m_hit();
    return pipe.size() == 2 && pipe[0].v && pipe[0].ins == HALT && !(flush || (start && m_state == M_RUN));
  endfunction
  function automatic logic m_pc_en();
    return m_state == M_RUN && !stall && !m_hit();
  endfunction
  always @(posedge clk) begin : model
    logic hh, fl;
    hh = m_hit();
    fl = flush || (start && m_state == M_RUN);
    if (!rst_n) begin
      m_state = M_IDLE; m_done = 0; m_cnt = 0; m_cnt4 = 0;
      pipe = {slot_t'(0), slot_t'(0)};
    end else begin
      if (pipe[0].v && !stall && !flush) begin
        m_cnt  = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
        m_cnt4 = m_cnt4 < 15 ? m_cnt4 + 1 : m_cnt4;
      end
      if (start) begin m_cnt = 0; m_cnt4 = 0; end
      if (hh) begin
        m_state = M_HALT; m_done = 1; pipe[0].v = 0; pipe[1].v = 0;
      end else begin
        if (!stall) begin
          void'(pipe.pop_front());
          pipe.push_back(slot_t'{m_state == M_RUN, pc, rom[pc]});
        end
        if (fl) begin pipe[0].v = 0; pipe[1].v = 0; end
        if (start) begin m_state = M_RUN; m_done = 0; end
      end
    end
  end
  task automatic test_reset();
    rst_n = 0; start = 0; stall = 0; flush = 0; jump = 0;
    repeat (2) @(negedge clk);
    total_cnt++; if (f.instr_out !== '0) $display("FAIL reset_instr_out got %0h exp 0", f.instr_out); else pass_cnt++;
    total_cnt++; if (f.instr_pc !== '0) $display("FAIL reset_instr_pc got %0h exp 0", f.instr_pc); else pass_cnt++;
    total_cnt++; if (f.instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", f.instr_valid); else pass_cnt++;
    total_cnt++; if (f.done !== 1'b0) $display("FAIL reset_done got %b exp 0", f.done); else pass_cnt++;
    total_cnt++; if (f.fetch_count !== '0) $display("FAIL reset_count got %0d exp 0", f.fetch_count); else pass_cnt++;
    total_cnt++; if (f.pc_en !== 1'b0) $display("FAIL reset_pc_en got %b exp 0", f.pc_en); else pass_cnt++;
    rst_n = 1;
    @(negedge clk);
    total_cnt++; if (f.pc_en !== 1'b0) $display("FAIL idle_pc_en got %b exp 0", f.pc_en); else pass_cnt++;
  endtask
  task automatic test_stream();
    start = 1;
    @(negedge clk); start = 0;
    total_cnt++; if (f.instr_valid !== 1'b0) $display("FAIL stream_lat0 valid got %b exp 0", f.instr_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (f.instr_valid !== 1'b0) $display("FAIL stream_lat1 valid got %b exp 0", f.instr_valid); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (f.instr_valid !== 1'b1 || f.instr_pc !== D'(i) || f.instr_out !== W'(i + 1))
        $display("FAIL stream_%0d got v=%b pc=%0d ins=%0d exp v=1 pc=%0d ins=%0d", i, f.instr_valid, f.instr_pc, f.instr_out, i, i + 1);
      else pass_cnt++;
    end
    total_cnt++; if (f.fetch_count !== 16'd3) $display("FAIL stream_count got %0d exp 3", f.fetch_count); else pass_cnt++;
  endtask
  task automatic test_stall();
    for (int i = 0; i < 10 && !(f.instr_valid && f.instr_pc == 5); i++) @(negedge clk);
    total_cnt++; if (!(f.instr_valid && f.instr_pc == 5)) $display("FAIL stall_reach pc got %0d exp 5", f.instr_pc); else pass_cnt++;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (f.instr_pc !== 12'd5 || f.instr_out !== 9'd6 || f.fetch_count !== 16'd5 || f.pc_en !== 1'b0 || f.instr_valid !== 1'b1)
        $display("FAIL stall_hold_%0d got pc=%0d ins=%0d cnt=%0d pc_en=%b exp pc=5 ins=6 cnt=5 pc_en=0", i, f.instr_pc, f.instr_out, f.fetch_count, f.pc_en);
      else pass_cnt++;
    end
    stall = 0;
    @(negedge clk);
    total_cnt++;
    if (f.instr_pc !== 12'd6 || f.instr_out !== 9'd7 || f.fetch_count !== 16'd6 || f.instr_valid !== 1'b1)
      $display("FAIL stall_release got pc=%0d ins=%0d cnt=%0d exp pc=6 ins=7 cnt=6", f.instr_pc, f.instr_out, f.fetch_count);
    else pass_cnt++;
  endtask
  task automatic test_flush();
    for (int i = 0; i < 10 && !(f.instr_valid && f.instr_pc == 7); i++) @(negedge clk);
    total_cnt++; if (!(f.instr_valid && f.instr_pc == 7)) $display("FAIL flush_reach pc got %0d exp 7", f.instr_pc); else pass_cnt++;
    flush = 1; jump = 1; jump_pc = 12'd16;
    @(negedge clk); flush = 0; jump = 0;
    total_cnt++; if (f.instr_valid !== 1'b0) $display("FAIL flush_bubble0 valid got %b exp 0", f.instr_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (f.instr_valid !== 1'b0) $display("FAIL flush_bubble1 valid got %b exp 0", f.instr_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (f.instr_valid !== 1'b1 || f.instr_pc !== 12'd16 || f.instr_out !== 9'd17)
      $display("FAIL flush_target got v=%b pc=%0d ins=%0d exp v=1 pc=16 ins=17", f.instr_valid, f.instr_pc, f.instr_out);
    else pass_cnt++;
    total_cnt++; if (f.fetch_count !== 16'd7) $display("FAIL flush_count got %0d exp 7", f.fetch_count); else pass_cnt++;
  endtask
  task automatic test_halt();
    int c;
    flush = 1; jump = 1; jump_pc = 12'd8;
    @(negedge clk); flush = 0; jump = 0;
    for (int i = 0; i < 10 && !(f.instr_valid && f.instr_pc == 10); i++) @(negedge clk);
    total_cnt++; if (f.instr_out !== HALT) $display("FAIL halt_reach ins got %0h exp %0h", f.instr_out, HALT); else pass_cnt++;
    total_cnt++; if (f.pc_en !== 1'b0) $display("FAIL halt_pc_en_hit got %b exp 0", f.pc_en); else pass_cnt++;
    c = m_cnt;
    @(negedge clk);
    total_cnt++;
    if (f.done !== 1'b1 || f.instr_valid !== 1'b0 || f.pc_en !== 1'b0)
      $display("FAIL halt_enter got done=%b v=%b pc_en=%b exp done=1 v=0 pc_en=0", f.done, f.instr_valid, f.pc_en);
    else pass_cnt++;
    total_cnt++; if (f.fetch_count !== 16'(c + 1)) $display("FAIL halt_count got %0d exp %0d", f.fetch_count, c + 1); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (f.done !== 1'b1 || f.instr_valid !== 1'b0) $display("FAIL halt_hold got done=%b v=%b exp done=1 v=0", f.done, f.instr_valid); else pass_cnt++;
    start = 1; jump = 1; jump_pc = 12'd128;
    @(negedge clk); start = 0; jump = 0;
    total_cnt++; if (f.done !== 1'b0 || f.fetch_count !== '0) $display("FAIL halt_restart got done=%b cnt=%0d exp done=0 cnt=0", f.done, f.fetch_count); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (f.instr_valid !== 1'b1 || f.instr_pc !== 12'd128 || f.instr_out !== 9'd129)
      $display("FAIL halt_resume got v=%b pc=%0d ins=%0d exp v=1 pc=128 ins=129", f.instr_valid, f.instr_pc, f.instr_out);
    else pass_cnt++;
  endtask
  task automatic test_flush_stall_reset();
    stall = 1; flush = 1; jump = 1; jump_pc = 12'd40;
    @(negedge clk); stall = 0; flush = 0; jump = 0;
    total_cnt++; if (f.instr_valid !== 1'b0) $display("FAIL fs_bubble0 valid got %b exp 0", f.instr_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (f.instr_valid !== 1'b0) $display("FAIL fs_bubble1 valid got %b exp 0", f.instr_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (f.instr_valid !== 1'b1 || f.instr_pc !== 12'd40 || f.instr_out !== 9'd41)
      $display("FAIL fs_target got v=%b pc=%0d ins=%0d exp v=1 pc=40 ins=41", f.instr_valid, f.instr_pc, f.instr_out);
    else pass_cnt++;
    flush = 1; jump = 1; jump_pc = 12'd9;
    @(negedge clk); flush = 0; jump = 0;
    for (int i = 0; i < 10 && !(f.instr_valid && f.instr_pc == 10); i++) @(negedge clk);
    flush = 1; jump = 1; jump_pc = 12'd20;
    @(negedge clk); flush = 0; jump = 0;
    total_cnt++;
    if (f.done !== 1'b0 || f.instr_valid !== 1'b0 || f.pc_en !== 1'b1)
      $display("FAIL halt_cancel got done=%b v=%b pc_en=%b exp done=0 v=0 pc_en=1", f.done, f.instr_valid, f.pc_en);
    else pass_cnt++;
    stall = 1; rst_n = 0;
    @(negedge clk); stall = 0;
    #1;
    total_cnt++;
    if (f.instr_valid !== 1'b0 || f.done !== 1'b0 || f.fetch_count !== '0 || f.instr_out !== '0 || f.instr_pc !== '0 || f.pc_en !== 1'b0)
      $display("FAIL mid_reset got v=%b done=%b cnt=%0d ins=%0h pc=%0h pc_en=%b exp all 0", f.instr_valid, f.done, f.fetch_count, f.instr_out, f.instr_pc, f.pc_en);
    else pass_cnt++;
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_saturate();
    start = 1; jump = 1; jump_pc = 12'd200;
    @(negedge clk); start = 0; jump = 0;
    repeat (25) @(negedge clk);
    total_cnt++; if (f.fetch_count !== 16'd23) $display("FAIL sat_wide_count got %0d exp 23", f.fetch_count); else pass_cnt++;
    total_cnt++; if (f4.fetch_count !== 4'd15) $display("FAIL sat_cw4_count got %0d exp 15", f4.fetch_count); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (f4.fetch_count !== 4'd15) $display("FAIL sat_cw4_hold got %0d exp 15", f4.fetch_count); else pass_cnt++;
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      total_cnt++; if (f.instr_valid !== pipe[0].v) $display("FAIL rnd_valid cyc %0d got %b exp %b", n, f.instr_valid, pipe[0].v); else pass_cnt++;
      if (pipe[0].v) begin
        total_cnt++;
        if (f.instr_pc !== pipe[0].pc || f.instr_out !== pipe[0].ins)
          $display("FAIL rnd_instr cyc %0d got pc=%0d ins=%0h exp pc=%0d ins=%0h", n, f.instr_pc, f.instr_out, pipe[0].pc, pipe[0].ins);
        else pass_cnt++;
      end
      total_cnt++; if (f.done !== m_done) $display("FAIL rnd_done cyc %0d got %b exp %b", n, f.done, m_done); else pass_cnt++;
      total_cnt++; if (f.fetch_count !== 16'(m_cnt)) $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, f.fetch_count, m_cnt); else pass_cnt++;
      total_cnt++; if (f4.fetch_count !== 4'(m_cnt4)) $display("FAIL rnd_count4 cyc %0d got %0d exp %0d", n, f4.fetch_count, m_cnt4); else pass_cnt++;
      total_cnt++; if (f.pc_en !== m_pc_en()) $display("FAIL rnd_pc_en cyc %0d got %b exp %b", n, f.pc_en, m_pc_en()); else pass_cnt++;
      stall   = $urandom % 10 < 3;
      flush   = $urandom % 10 == 0;
      start   = m_done ? $urandom % 4 == 0 : $urandom % 60 == 0;
      jump    = flush | start;
      jump_pc = $urandom % 3 == 0 ? 12'd8 : 12'($urandom_range(0, 4095));
    end
    stall = 0; flush = 0; start = 0; jump = 0;
  endtask
  initial begin
    for (int i = 0; i < 2**D; i++) rom[i] = W'(i % 500 + 1);
    rom[10] = HALT;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_halt();
    test_flush_stall_reset();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
